i2c_target_mem: RTL and testbench

// - I2C target (slave) with an internal byte memory. Sits on the SCL/SDA bus opposite the team's single-byte I2C master.
// - The 7-bit field after START is the memory index (no separate device address); R/W bit = LSB of the first byte.
// - Write: stores data bytes. Read: returns stored bytes. Open-drain SDA; sampled in the clk domain.

---
 rtl/i2c_pkg.sv | 34 +++
 rtl/i2c_line_sync.sv | 61 ++++++
 rtl/i2c_target_mem.sv | 217 +++++++++++++++++++++
 tb/tb_i2c_target_mem.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/i2c_pkg.sv
// Shared types, widths and index helpers for the I2C memory target.
package i2c_pkg;

  localparam int I2C_IDX_W  = 7;
  localparam int I2C_BYTE_W = 8;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    ADDR      = 3'd1,
    ADDR_ACK  = 3'd2,
    WR_DATA   = 3'd3,
    WR_ACK    = 3'd4,
    RD_DATA   = 3'd5,
    RD_MACK   = 3'd6,
    WAIT_STOP = 3'd7
  } i2c_tgt_state_t;

  function automatic logic i2c_idx_ok(input logic [I2C_IDX_W-1:0] idx, input int depth);
    return ({1'b0, idx} < 8'(depth));
  endfunction

  // Auto-increment that wraps from the last stored byte back to index 0.
  function automatic logic [I2C_IDX_W-1:0] i2c_idx_next(input logic [I2C_IDX_W-1:0] idx,
                                                        input int depth);
    logic [I2C_IDX_W-1:0] nxt;
    if ({1'b0, idx} >= 8'(depth - 1)) begin
      nxt = {I2C_IDX_W{1'b0}};
    end else begin
      nxt = idx + 7'd1;
    end
    return nxt;
  endfunction

endpackage

// File: rtl/i2c_line_sync.sv
// Synchronises scl/sda into clk and produces registered levels, scl edges and START/STOP strobes.
module i2c_line_sync #(
  parameter int SYNC_STG = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic scl,
  input  logic sda,
  output logic sda_lvl,
  output logic scl_rise,
  output logic scl_fall,
  output logic start_det,
  output logic stop_det
);

  logic [SYNC_STG-1:0] scl_sync_r;
  logic [SYNC_STG-1:0] sda_sync_r;
  logic                scl_lvl_r;
  logic                sda_lvl_r;
  logic                scl_rise_r;
  logic                scl_fall_r;
  logic                start_r;
  logic                stop_r;
  logic                scl_s;
  logic                sda_s;
  logic                scl_edge_s;

  assign scl_s      = scl_sync_r[SYNC_STG-1];
  assign sda_s      = sda_sync_r[SYNC_STG-1];
  assign scl_edge_s = scl_s ^ scl_lvl_r;

  // Flops idle high so a reset never fabricates a bus edge; an scl edge masks START/STOP in the same clk.
  always_ff @(posedge clk) begin
    if (rst) begin
      scl_sync_r <= {SYNC_STG{1'b1}};
      sda_sync_r <= {SYNC_STG{1'b1}};
      scl_lvl_r  <= 1'b1;
      sda_lvl_r  <= 1'b1;
      scl_rise_r <= 1'b0;
      scl_fall_r <= 1'b0;
      start_r    <= 1'b0;
      stop_r     <= 1'b0;
    end else begin
      scl_sync_r <= {scl_sync_r[SYNC_STG-2:0], scl};
      sda_sync_r <= {sda_sync_r[SYNC_STG-2:0], sda};
      scl_lvl_r  <= scl_s;
      sda_lvl_r  <= sda_s;
      scl_rise_r <= scl_s & ~scl_lvl_r;
      scl_fall_r <= ~scl_s & scl_lvl_r;
      start_r    <= ~scl_edge_s & scl_lvl_r & sda_lvl_r & ~sda_s;
      stop_r     <= ~scl_edge_s & scl_lvl_r & ~sda_lvl_r & sda_s;
    end
  end

  assign sda_lvl   = sda_lvl_r;
  assign scl_rise  = scl_rise_r;
  assign scl_fall  = scl_fall_r;
  assign start_det = start_r;
  assign stop_det  = stop_r;

endmodule

// File: rtl/i2c_target_mem.sv
// I2C target whose first byte selects a memory index; following bytes are written or read with auto-increment.
module i2c_target_mem
  import i2c_pkg::*;
#(
  parameter int MEM_DEPTH = 128,
  parameter int SYNC_STG  = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  scl,
  inout  logic                  sda,
  output logic                  busy,
  output logic                  done,
  output logic                  last_op,
  output logic [I2C_IDX_W-1:0]  last_addr,
  output logic [I2C_BYTE_W-1:0] last_data,
  output logic                  nack_sent
);

  localparam int MEM_AW = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;

  logic                  sda_lvl_s;
  logic                  scl_rise_s;
  logic                  scl_fall_s;
  logic                  start_det_s;
  logic                  stop_det_s;
  logic                  idx_ok_s;
  logic [I2C_BYTE_W-1:0] mem_rd_s;

  i2c_tgt_state_t        state_r;
  logic [3:0]            bit_cnt_r;
  logic [I2C_IDX_W-1:0]  shift_r;
  logic [I2C_IDX_W-1:0]  idx_r;
  logic                  rw_r;
  logic [I2C_BYTE_W-1:0] tx_r;
  logic                  sda_oe_r;
  logic                  busy_r;
  logic                  done_r;
  logic                  last_op_r;
  logic [I2C_IDX_W-1:0]  last_addr_r;
  logic [I2C_BYTE_W-1:0] last_data_r;
  logic                  nack_r;
  logic [I2C_BYTE_W-1:0] mem_r [0:MEM_DEPTH-1];

  i2c_line_sync #(.SYNC_STG(SYNC_STG)) u_line_sync (
    .clk       (clk),
    .rst       (rst),
    .scl       (scl),
    .sda       (sda),
    .sda_lvl   (sda_lvl_s),
    .scl_rise  (scl_rise_s),
    .scl_fall  (scl_fall_s),
    .start_det (start_det_s),
    .stop_det  (stop_det_s)
  );

  assign idx_ok_s = i2c_idx_ok(idx_r, MEM_DEPTH);
  assign mem_rd_s = mem_r[idx_r[MEM_AW-1:0]];

  // Bus protocol FSM together with the byte store; START/STOP override every state.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r     <= IDLE;
      bit_cnt_r   <= 4'd0;
      shift_r     <= 7'd0;
      idx_r       <= 7'd0;
      rw_r        <= 1'b0;
      tx_r        <= 8'h00;
      sda_oe_r    <= 1'b0;
      busy_r      <= 1'b0;
      done_r      <= 1'b0;
      last_op_r   <= 1'b0;
      last_addr_r <= 7'd0;
      last_data_r <= 8'h00;
      nack_r      <= 1'b0;
      for (int i = 0; i < MEM_DEPTH; i++) begin
        mem_r[i] <= 8'h00;
      end
    end else begin
      done_r <= 1'b0;
      if (start_det_s) begin
        state_r   <= ADDR;
        bit_cnt_r <= 4'd0;
        sda_oe_r  <= 1'b0;
        busy_r    <= 1'b1;
        nack_r    <= 1'b0;
      end else if (stop_det_s) begin
        state_r   <= IDLE;
        bit_cnt_r <= 4'd0;
        sda_oe_r  <= 1'b0;
        done_r    <= busy_r;
        busy_r    <= 1'b0;
      end else begin
        case (state_r)
          IDLE: begin
            sda_oe_r <= 1'b0;
          end
          ADDR: begin
            if (scl_rise_s) begin
              if (bit_cnt_r == 4'd7) begin
                idx_r     <= shift_r;
                rw_r      <= sda_lvl_s;
                bit_cnt_r <= 4'd0;
                state_r   <= ADDR_ACK;
              end else begin
                shift_r   <= {shift_r[5:0], sda_lvl_s};
                bit_cnt_r <= bit_cnt_r + 4'd1;
              end
            end
          end
          // bit_cnt_r distinguishes the ack-driving fall from the ack-releasing fall.
          ADDR_ACK: begin
            if (scl_fall_s) begin
              if (bit_cnt_r == 4'd0) begin
                bit_cnt_r <= 4'd1;
                if (idx_ok_s) begin
                  sda_oe_r  <= 1'b1;
                  last_op_r <= rw_r;
                end else begin
                  sda_oe_r <= 1'b0;
                  nack_r   <= 1'b1;
                end
              end else begin
                bit_cnt_r <= 4'd0;
                if (!idx_ok_s) begin
                  sda_oe_r <= 1'b0;
                  state_r  <= WAIT_STOP;
                end else if (!rw_r) begin
                  sda_oe_r <= 1'b0;
                  state_r  <= WR_DATA;
                end else begin
                  tx_r     <= mem_rd_s;
                  sda_oe_r <= ~mem_rd_s[7];
                  state_r  <= RD_DATA;
                end
              end
            end
          end
          WR_DATA: begin
            if (scl_rise_s) begin
              if (bit_cnt_r == 4'd7) begin
                mem_r[idx_r[MEM_AW-1:0]] <= {shift_r, sda_lvl_s};
                last_addr_r <= idx_r;
                last_data_r <= {shift_r, sda_lvl_s};
                bit_cnt_r   <= 4'd0;
                state_r     <= WR_ACK;
              end else begin
                shift_r   <= {shift_r[5:0], sda_lvl_s};
                bit_cnt_r <= bit_cnt_r + 4'd1;
              end
            end
          end
          WR_ACK: begin
            if (scl_fall_s) begin
              if (bit_cnt_r == 4'd0) begin
                sda_oe_r  <= 1'b1;
                bit_cnt_r <= 4'd1;
              end else begin
                sda_oe_r  <= 1'b0;
                idx_r     <= i2c_idx_next(idx_r, MEM_DEPTH);
                bit_cnt_r <= 4'd0;
                state_r   <= WR_DATA;
              end
            end
          end
          RD_DATA: begin
            if (scl_fall_s) begin
              if (bit_cnt_r == 4'd7) begin
                sda_oe_r    <= 1'b0;
                last_addr_r <= idx_r;
                last_data_r <= tx_r;
                bit_cnt_r   <= 4'd0;
                state_r     <= RD_MACK;
              end else begin
                sda_oe_r  <= ~tx_r[3'd6 - bit_cnt_r[2:0]];
                bit_cnt_r <= bit_cnt_r + 4'd1;
              end
            end
          end
          // Master ACK advances the index on the rise; the next byte's MSB goes out on the fall.
          RD_MACK: begin
            if (scl_rise_s && (bit_cnt_r == 4'd0)) begin
              if (!sda_lvl_s) begin
                idx_r     <= i2c_idx_next(idx_r, MEM_DEPTH);
                bit_cnt_r <= 4'd1;
              end else begin
                state_r <= WAIT_STOP;
              end
            end else if (scl_fall_s && (bit_cnt_r == 4'd1)) begin
              tx_r      <= mem_rd_s;
              sda_oe_r  <= ~mem_rd_s[7];
              bit_cnt_r <= 4'd0;
              state_r   <= RD_DATA;
            end
          end
          WAIT_STOP: begin
            sda_oe_r <= 1'b0;
          end
          default: begin
            sda_oe_r  <= 1'b0;
            bit_cnt_r <= 4'd0;
            state_r   <= IDLE;
          end
        endcase
      end
    end
  end

  assign sda       = sda_oe_r ? 1'b0 : 1'bz;
  assign busy      = busy_r;
  assign done      = done_r;
  assign last_op   = last_op_r;
  assign last_addr = last_addr_r;
  assign last_data = last_data_r;
  assign nack_sent = nack_r;

endmodule

// File: tb/tb_i2c_target_mem.sv
// Bench: bit-banged I2C master against a 128-byte and a 64-byte target; done pulses drive a scoreboard.
module tb_i2c_target_mem;

  localparam int Q = 8;

  typedef struct packed {
    logic       op;
    logic [6:0] addr;
    logic [7:0] data;
    logic       nack;
    logic       err;
    logic [7:0] rd0;
    logic [7:0] rd1;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst;
  logic       scl;
  logic       m_low;
  logic       sel;
  wire        sda0;
  wire        sda1;
  logic       busy0, done0, lop0, nack0;
  logic [6:0] laddr0;
  logic [7:0] ldata0;
  logic       busy1, done1, lop1, nack1;
  logic [6:0] laddr1;
  logic [7:0] ldata1;

  logic       obs_err;
  logic [7:0] obs_rd0;
  logic [7:0] obs_rd1;
  exp_t       exp_q0[$];
  exp_t       exp_q1[$];
  int         n_vec = 0;
  int         n_bad = 0;

  pullup (sda0);
  pullup (sda1);
  assign sda0 = (m_low && !sel) ? 1'b0 : 1'bz;
  assign sda1 = (m_low && sel) ? 1'b0 : 1'bz;

  always #5 clk = ~clk;

  i2c_target_mem #(.MEM_DEPTH(128), .SYNC_STG(2)) u_dut0 (
    .clk(clk), .rst(rst), .scl(scl), .sda(sda0), .busy(busy0), .done(done0),
    .last_op(lop0), .last_addr(laddr0), .last_data(ldata0), .nack_sent(nack0)
  );

  i2c_target_mem #(.MEM_DEPTH(64), .SYNC_STG(2)) u_dut1 (
    .clk(clk), .rst(rst), .scl(scl), .sda(sda1), .busy(busy1), .done(done1),
    .last_op(lop1), .last_addr(laddr1), .last_data(ldata1), .nack_sent(nack1)
  );

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic compare_rec(input string tag, input exp_t e, input logic op,
                             input logic [6:0] addr, input logic [7:0] data, input logic nk);
    check({tag, "_last_op"},   16'(op),      16'(e.op));
    check({tag, "_last_addr"}, 16'(addr),    16'(e.addr));
    check({tag, "_last_data"}, 16'(data),    16'(e.data));
    check({tag, "_nack_sent"}, 16'(nk),      16'(e.nack));
    check({tag, "_ack_err"},   16'(obs_err), 16'(e.err));
    check({tag, "_rd0"},       16'(obs_rd0), 16'(e.rd0));
    check({tag, "_rd1"},       16'(obs_rd1), 16'(e.rd1));
  endtask

  // Monitor: every done pulse retires one expected transaction of that bus.
  always @(negedge clk) begin
    if (done0) begin
      if (exp_q0.size() == 0) begin
        n_vec++;
        n_bad++;
        $display("FAIL done0_unexpected: actual=1 required=0");
      end else begin
        compare_rec("bus0", exp_q0.pop_front(), lop0, laddr0, ldata0, nack0);
      end
    end
    if (done1) begin
      if (exp_q1.size() == 0) begin
        n_vec++;
        n_bad++;
        $display("FAIL done1_unexpected: actual=1 required=0");
      end else begin
        compare_rec("bus1", exp_q1.pop_front(), lop1, laddr1, ldata1, nack1);
      end
    end
  end

  task automatic wq(input int n);
    repeat (n * Q) @(negedge clk);
  endtask

  task automatic bus_start();
    m_low = 1'b1; wq(2);
    scl = 1'b0;   wq(1);
  endtask

  task automatic bus_stop();
    m_low = 1'b1; wq(1);
    scl = 1'b1;   wq(2);
    m_low = 1'b0; wq(4);
  endtask

  task automatic send_bit(input logic b);
    m_low = !b; wq(1);
    scl = 1'b1; wq(2);
    scl = 1'b0; wq(1);
  endtask

  task automatic read_bit(output logic b);
    m_low = 1'b0; wq(1);
    scl = 1'b1;   wq(1);
    b = sel ? sda1 : sda0;
    wq(1);
    scl = 1'b0;   wq(1);
  endtask

  task automatic send_byte(input logic [7:0] v, output logic nak);
    for (int i = 7; i >= 0; i--) send_bit(v[i]);
    read_bit(nak);
  endtask

  task automatic recv_byte(output logic [7:0] v, input logic ack);
    logic b;
    v = 8'h00;
    for (int i = 7; i >= 0; i--) begin
      read_bit(b);
      v[i] = b;
    end
    send_bit(!ack);
  endtask

  // One framed transfer; the hand-computed expectation is queued before the STOP.
  task automatic xfer(input logic bus, input logic rw, input logic [6:0] idx, input int n,
                      input logic [7:0] w0, input logic [7:0] w1,
                      input logic e_op, input logic [6:0] e_addr, input logic [7:0] e_data,
                      input logic e_nack, input logic e_err, input logic [7:0] e_rd0,
                      input logic [7:0] e_rd1);
    exp_t       e;
    logic       nak;
    logic       err;
    logic [7:0] b;
    logic [7:0] rd0;
    logic [7:0] rd1;
    sel = bus;
    rd0 = 8'h00;
    rd1 = 8'h00;
    bus_start();
    send_byte({idx, rw}, nak);
    err = nak;
    if (!nak) begin
      for (int i = 0; i < n; i++) begin
        if (rw) begin
          recv_byte(b, (i < n - 1));
          if (i == 0) rd0 = b;
          else rd1 = b;
        end else begin
          send_byte((i == 0) ? w0 : w1, nak);
          err = err | nak;
        end
      end
    end
    obs_err = err;
    obs_rd0 = rd0;
    obs_rd1 = rd1;
    e.op = e_op; e.addr = e_addr; e.data = e_data; e.nack = e_nack;
    e.err = e_err; e.rd0 = e_rd0; e.rd1 = e_rd1;
    if (bus) exp_q1.push_back(e);
    else exp_q0.push_back(e);
    bus_stop();
  endtask

  initial begin
    logic nak;
    logic bt;
    rst = 1'b1; scl = 1'b1; m_low = 1'b0; sel = 1'b0;
    obs_err = 1'b0; obs_rd0 = 8'h00; obs_rd1 = 8'h00;
    repeat (5) @(negedge clk);
    rst = 1'b0;
    repeat (5) @(negedge clk);
    check("rst_busy",      16'(busy0),  16'h0);
    check("rst_done",      16'(done0),  16'h0);
    check("rst_last_op",   16'(lop0),   16'h0);
    check("rst_last_addr", 16'(laddr0), 16'h0);
    check("rst_last_data", 16'(ldata0), 16'h0);
    check("rst_nack_sent", 16'(nack0),  16'h0);
    check("rst_sda",       16'(sda0),   16'h1);

    //   bus rw  idx    n  w0     w1     op  addr   data   nk  err  rd0    rd1
    xfer(0, 0, 7'h12, 1, 8'hA5, 8'h00, 0, 7'h12, 8'hA5, 0, 0, 8'h00, 8'h00);
    xfer(0, 1, 7'h12, 1, 8'h00, 8'h00, 1, 7'h12, 8'hA5, 0, 0, 8'hA5, 8'h00);
    xfer(0, 1, 7'h05, 1, 8'h00, 8'h00, 1, 7'h05, 8'h00, 0, 0, 8'h00, 8'h00);
    xfer(0, 0, 7'h7F, 2, 8'h11, 8'h22, 0, 7'h00, 8'h22, 0, 0, 8'h00, 8'h00);
    xfer(0, 1, 7'h7F, 2, 8'h00, 8'h00, 1, 7'h00, 8'h22, 0, 0, 8'h11, 8'h22);
    xfer(0, 0, 7'h40, 1, 8'h5A, 8'h00, 0, 7'h40, 8'h5A, 0, 0, 8'h00, 8'h00);
    xfer(0, 1, 7'h3F, 2, 8'h00, 8'h00, 1, 7'h40, 8'h5A, 0, 0, 8'h00, 8'h5A);
    xfer(1, 0, 7'h10, 1, 8'h77, 8'h00, 0, 7'h10, 8'h77, 0, 0, 8'h00, 8'h00);
    xfer(1, 0, 7'h50, 1, 8'h3C, 8'h00, 0, 7'h10, 8'h77, 1, 1, 8'h00, 8'h00);
    xfer(1, 1, 7'h10, 1, 8'h00, 8'h00, 1, 7'h10, 8'h77, 0, 0, 8'h77, 8'h00);
    xfer(1, 1, 7'h3F, 1, 8'h00, 8'h00, 1, 7'h3F, 8'h00, 0, 0, 8'h00, 8'h00);
    xfer(1, 1, 7'h40, 1, 8'h00, 8'h00, 1, 7'h3F, 8'h00, 1, 1, 8'h00, 8'h00);
    xfer(1, 0, 7'h3F, 2, 8'hC3, 8'h96, 0, 7'h00, 8'h96, 0, 0, 8'h00, 8'h00);
    xfer(1, 1, 7'h00, 1, 8'h00, 8'h00, 1, 7'h00, 8'h96, 0, 0, 8'h96, 8'h00);

    // Reset while the target drives bit 4 (a 0) of 0xA5; the rest of the frame must be ignored.
    sel = 1'b0;
    bus_start();
    send_byte({7'h12, 1'b1}, nak);
    check("abort_addr_ack", 16'(nak), 16'h0);
    for (int i = 0; i < 3; i++) read_bit(bt);
    check("abort_bit4_driven", 16'(sda0),  16'h0);
    check("abort_busy_before", 16'(busy0), 16'h1);
    rst = 1'b1;
    @(negedge clk);
    check("abort_sda_released", 16'(sda0),   16'h1);
    check("abort_busy",         16'(busy0),  16'h0);
    check("abort_last_data",    16'(ldata0), 16'h0);
    rst = 1'b0;
    for (int i = 0; i < 4; i++) read_bit(bt);
    send_bit(1'b1);
    bus_stop();

    xfer(0, 1, 7'h12, 1, 8'h00, 8'h00, 1, 7'h12, 8'h00, 0, 0, 8'h00, 8'h00);
    xfer(1, 1, 7'h00, 1, 8'h00, 8'h00, 1, 7'h00, 8'h00, 0, 0, 8'h00, 8'h00);
    xfer(0, 0, 7'h12, 1, 8'hA5, 8'h00, 0, 7'h12, 8'hA5, 0, 0, 8'h00, 8'h00);
    xfer(0, 1, 7'h12, 1, 8'h00, 8'h00, 1, 7'h12, 8'hA5, 0, 0, 8'hA5, 8'h00);

    repeat (50) @(negedge clk);
    check("bus0_all_done_seen", 16'(exp_q0.size()), 16'h0);
    check("bus1_all_done_seen", 16'(exp_q1.size()), 16'h0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
